// File: rtl/led_io_pkg.sv
// led_io_pkg: register-map offsets and read-mux select type for the LED PWM bank.
// Offsets are expressed in terms of NB, the number of LED bytes (NUM_LEDS/8).
package led_io_pkg;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_ON,
        SEL_BLINK,
        SEL_DUTY,
        SEL_BDIV,
        SEL_STATUS
    } rd_sel_e;

    localparam int unsigned OFS_ON = 0;

    function automatic int unsigned OFS_BLINK(input int unsigned nb);
        return nb;
    endfunction

    function automatic int unsigned OFS_DUTY(input int unsigned nb);
        return 2 * nb;
    endfunction

    function automatic int unsigned OFS_BDIV(input int unsigned nb);
        return 2 * nb + 1;
    endfunction

    function automatic int unsigned OFS_STATUS(input int unsigned nb);
        return 2 * nb + 2;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen: shared PWM timebase; a prescaler steps pwm_cnt, which is compared
// against DUTY to give one brightness level used by every LED channel.
module led_pwm_gen #(
    parameter int PWM_BITS = 4,
    parameter int PWM_DIV  = 64
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [PWM_BITS-1:0] i_duty,
    output logic                o_pwm_on
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PW-1:0]       r_pre;
    logic [PWM_BITS-1:0] r_cnt;
    logic                w_step;

    assign w_step = (r_pre == PW'(PWM_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_pre <= '0;
            r_cnt <= r_cnt + PWM_BITS'(1);
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // All-ones duty is forced fully on; otherwise the top count would leave one dark step.
    assign o_pwm_on = (&i_duty) | (r_cnt < i_duty);

endmodule

// File: rtl/led_pwm_bank.sv
// led_pwm_bank: bus-mapped LED bank with per-LED enable, shared PWM brightness and optional blink.
// Define LED_BLINK_EN to build the BLINK/BLINK_DIV registers, tick divider and blink counter.
module led_pwm_bank
    import led_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hC0,
    parameter int         NUM_LEDS  = 16,
    parameter int         PWM_BITS  = 4,
    parameter int         PWM_DIV   = 64,
    parameter int         TICK_DIV  = 50000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    inout  wire  [7:0]          io_bus_data,
    input  logic [7:0]          i_bus_addr,
    input  logic                i_bus_we,
    output logic [NUM_LEDS-1:0] o_led_out
);

    localparam int NB   = NUM_LEDS / 8;
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;

    if ((NUM_LEDS % 8) != 0 || NUM_LEDS < 8 || NUM_LEDS > 32 || PWM_BITS < 2 || PWM_BITS > 8
        || PWM_DIV < 1 || TICK_DIV < 2) begin : g_bad_config
        $error("led_pwm_bank: unsupported parameter combination");
    end

    logic [8:0]         w_ofs;
    logic               w_in_win;
    logic               w_wr;
    rd_sel_e            w_sel;
    logic [IDXW-1:0]    w_idx;
    logic [NB-1:0][7:0] r_on;
    logic [PWM_BITS-1:0] r_duty;
    logic               w_pwm_on;
    logic [NUM_LEDS-1:0] w_blink_vec;
    logic               w_phase;
    logic [7:0]         w_blink_rd;
    logic [7:0]         w_bdiv_rd;
    logic [7:0]         w_rdata;
    logic               r_rd_en;
    logic [7:0]         r_rd_data;
    logic [NUM_LEDS-1:0] r_led;

    // Nine-bit offset so addresses below BASE_ADDR never alias into the window.
    assign w_ofs    = {1'b0, i_bus_addr} - {1'b0, BASE_ADDR};
    assign w_in_win = (i_bus_addr >= BASE_ADDR) && (w_ofs <= 9'(OFS_STATUS(NB)));
    assign w_wr     = i_bus_we && w_in_win;

    always_comb begin
        w_sel = SEL_NONE;
        w_idx = '0;
        if (w_in_win) begin
            if (w_ofs < 9'(OFS_BLINK(NB))) begin
                w_sel = SEL_ON;
                w_idx = IDXW'(w_ofs - 9'(OFS_ON));
            end else if (w_ofs < 9'(OFS_DUTY(NB))) begin
                w_sel = SEL_BLINK;
                w_idx = IDXW'(w_ofs - 9'(OFS_BLINK(NB)));
            end else if (w_ofs == 9'(OFS_DUTY(NB))) begin
                w_sel = SEL_DUTY;
            end else if (w_ofs == 9'(OFS_BDIV(NB))) begin
                w_sel = SEL_BDIV;
            end else begin
                w_sel = SEL_STATUS;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_on   <= '0;
            r_duty <= '1;
        end else if (w_wr) begin
            case (w_sel)
                SEL_ON:   r_on[w_idx] <= io_bus_data;
                SEL_DUTY: r_duty      <= io_bus_data[PWM_BITS-1:0];
                default:  ;
            endcase
        end
    end

    led_pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .PWM_DIV  (PWM_DIV)
    ) u_pwm_gen (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_duty   (r_duty),
        .o_pwm_on (w_pwm_on)
    );

`ifdef LED_BLINK_EN
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0]      r_tick_cnt;
    logic               w_tick;
    logic [NB-1:0][7:0] r_blink;
    logic [7:0]         r_bdiv;
    logic [7:0]         r_bcnt;
    logic               r_phase;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // A BLINK_DIV write restarts the half-period and wins over a same-cycle tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink <= '0;
            r_bdiv  <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else begin
            if (w_wr && (w_sel == SEL_BLINK)) begin
                r_blink[w_idx] <= io_bus_data;
            end
            if (w_wr && (w_sel == SEL_BDIV)) begin
                r_bdiv  <= io_bus_data;
                r_bcnt  <= '0;
                r_phase <= 1'b1;
            end else if (r_bdiv == 8'd0) begin
                r_phase <= 1'b1;
            end else if (w_tick) begin
                if (r_bcnt == r_bdiv - 8'd1) begin
                    r_bcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_bcnt <= r_bcnt + 8'd1;
                end
            end
        end
    end

    assign w_blink_vec = r_blink;
    assign w_phase     = r_phase;
    assign w_blink_rd  = r_blink[w_idx];
    assign w_bdiv_rd   = r_bdiv;
`else
    assign w_blink_vec = '0;
    assign w_phase     = 1'b1;
    assign w_blink_rd  = 8'h00;
    assign w_bdiv_rd   = 8'h00;
`endif

    always_comb begin
        w_rdata = 8'h00;
        case (w_sel)
            SEL_ON:     w_rdata = r_on[w_idx];
            SEL_BLINK:  w_rdata = w_blink_rd;
            SEL_DUTY:   w_rdata = 8'(r_duty);
            SEL_BDIV:   w_rdata = w_bdiv_rd;
            SEL_STATUS: w_rdata = {6'b0, w_pwm_on, w_phase};
            default:    w_rdata = 8'h00;
        endcase
    end

    // Read data is captured at the address edge and driven for exactly the following cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_en   <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_rd_en   <= !i_bus_we && w_in_win;
            r_rd_data <= w_rdata;
        end
    end

    assign io_bus_data = r_rd_en ? r_rd_data : 8'hzz;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= r_on & {NUM_LEDS{w_pwm_on}} & (~w_blink_vec | {NUM_LEDS{w_phase}});
        end
    end

    assign o_led_out = r_led;

endmodule
